// File: rtl/nanosoc_busmatrix_pkg.sv
// nanosoc_busmatrix_pkg
//   Shared definitions for the nanosoc bus matrix: AHB transfer-type,
//   burst and response encodings, the bundled address-phase control
//   fields, and a small helper used by input stages and arbiters.
//   No ports; imported with: import nanosoc_busmatrix_pkg::*;
package nanosoc_busmatrix_pkg;

  // HTRANS encodings
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // HBURST encodings
  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  // HRESP encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Address-phase control fields other than HSEL and HADDR. HSEL is not
  // stored because a held transfer is by definition selected.
  typedef struct packed {
    logic [1:0] trans;
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
    logic       mastlock;
  } ahb_ctrl_t;

  // NONSEQ and SEQ both have HTRANS[1] set; IDLE and BUSY carry no
  // transfer and must never be captured or waited on.
  function automatic logic trans_is_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/nanosoc_addr_hold_reg.sv
// nanosoc_addr_hold_reg
//   Enable-loaded register bank holding one AHB address phase while the
//   input stage waits for its target output port to be granted.
// Ports:
//   HCLK     in   clock
//   HRESETn  in   async active-low reset, clears all fields to zero
//   i_load   in   capture i_addr/i_ctrl on this edge
//   i_addr   in   ADDR_W address to capture
//   i_ctrl   in   control fields to capture
//   o_addr   out  held address
//   o_ctrl   out  held control fields
module nanosoc_addr_hold_reg
  import nanosoc_busmatrix_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  ahb_ctrl_t         i_ctrl,
  output logic [ADDR_W-1:0] o_addr,
  output ahb_ctrl_t         o_ctrl
);

  logic [ADDR_W-1:0] r_addr;
  ahb_ctrl_t         r_ctrl;

  // Load the whole address phase in one go so the fields can never be
  // out of step with each other.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr <= '0;
      r_ctrl <= '0;
    end else if (i_load) begin
      r_addr <= i_addr;
      r_ctrl <= i_ctrl;
    end
  end

  assign o_addr = r_addr;
  assign o_ctrl = r_ctrl;

endmodule

// File: rtl/nanosoc_input_hold_stage.sv
// nanosoc_input_hold_stage
//   Per-master AHB input stage of the nanosoc bus matrix. Forwards the
//   master's address phase to the decoder/arbiters, holds it when the
//   target port is not granted (inserting wait states to the master), and
//   returns the slave's data-phase ready/response once granted.
// Ports:
//   HCLK, HRESETn          clock, async active-low reset
//   HSELS..HMASTLOCKS      master address phase
//   HREADYS                matrix-level HREADY seen by the master
//   HREADYOUTS, HRESPS     ready/response returned to the master
//   sel_m..mastlock_m      address phase presented to decoder/arbiters
//   trans_req              request toward the output arbiters
//   active_dec             targeted output port has selected this input
//   readyout_dec, resp_dec data-phase HREADYOUT/HRESP from targeted slave
module nanosoc_input_hold_stage
  import nanosoc_busmatrix_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic              HRESPS,
  output logic              sel_m,
  output logic [ADDR_W-1:0] addr_m,
  output logic [1:0]        trans_m,
  output logic              write_m,
  output logic [2:0]        size_m,
  output logic [2:0]        burst_m,
  output logic [3:0]        prot_m,
  output logic              mastlock_m,
  output logic              trans_req,
  input  logic              active_dec,
  input  logic              readyout_dec,
  input  logic              resp_dec
);

  logic              r_pend;
  logic              r_data_phase;
  logic              w_trans_valid;
  logic              w_pend_set;
  logic              w_pend_clear;
  ahb_ctrl_t         w_master_ctrl;
  ahb_ctrl_t         w_hold_ctrl;
  ahb_ctrl_t         w_fwd_ctrl;
  logic [ADDR_W-1:0] w_hold_addr;

  assign w_master_ctrl = '{
    trans:    HTRANSS,
    write:    HWRITES,
    size:     HSIZES,
    burst:    HBURSTS,
    prot:     HPROTS,
    mastlock: HMASTLOCKS
  };

  // A real transfer is being offered only when selected, NONSEQ/SEQ and the
  // previous transfer on the matrix has completed.
  assign w_trans_valid = HSELS & trans_is_active(HTRANSS) & HREADYS;

  // Set is gated by !r_pend so the hold registers cannot be overwritten
  // while a held transfer is still waiting. Clear happens when the slave
  // path has both selected us and is ready to take our address phase.
  assign w_pend_set   = ~r_pend & w_trans_valid & ~active_dec;
  assign w_pend_clear =  r_pend & active_dec & readyout_dec;

  nanosoc_addr_hold_reg #(
    .ADDR_W (ADDR_W)
  ) u_hold (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .i_load  (w_pend_set),
    .i_addr  (HADDRS),
    .i_ctrl  (w_master_ctrl),
    .o_addr  (w_hold_addr),
    .o_ctrl  (w_hold_ctrl)
  );

  // Pending flag: marks that the hold registers contain an un-granted
  // address phase that must be presented in place of the master's inputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pend <= 1'b0;
    end else if (w_pend_set) begin
      r_pend <= 1'b1;
    end else if (w_pend_clear) begin
      r_pend <= 1'b0;
    end
  end

  // Data-phase flag: this master owns the current data phase of the slave
  // path. Entered either by a granted same-cycle transfer or when a held
  // transfer is finally accepted; otherwise only updated when the matrix
  // HREADY marks the end of the current data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_data_phase <= 1'b0;
    end else if (w_pend_clear) begin
      r_data_phase <= 1'b1;
    end else if (HREADYS && !r_pend) begin
      r_data_phase <= w_trans_valid & active_dec;
    end
  end

  // Address-phase mux: the held copy wins while pending, otherwise the
  // master's phase goes straight through with no added latency. HTRANS is
  // held unchanged so a held SEQ still looks like SEQ to the arbiter.
  assign w_fwd_ctrl = r_pend ? w_hold_ctrl : w_master_ctrl;
  assign sel_m      = r_pend ? 1'b1        : HSELS;
  assign addr_m     = r_pend ? w_hold_addr : HADDRS;
  assign trans_m    = w_fwd_ctrl.trans;
  assign write_m    = w_fwd_ctrl.write;
  assign size_m     = w_fwd_ctrl.size;
  assign burst_m    = w_fwd_ctrl.burst;
  assign prot_m     = w_fwd_ctrl.prot;
  assign mastlock_m = w_fwd_ctrl.mastlock;

  assign trans_req = r_pend | w_trans_valid;

  // Response path toward the master. Wait states while holding; otherwise
  // the slave's ready during our data phase, and idle-ready when we have
  // no data phase outstanding.
  always_comb begin
    HREADYOUTS = 1'b1;
    if (r_pend) begin
      HREADYOUTS = 1'b0;
    end else if (r_data_phase) begin
      HREADYOUTS = readyout_dec;
    end
  end

  assign HRESPS = r_data_phase ? resp_dec : HRESP_OKAY;

endmodule

// File: tb/tb_nanosoc_input_hold_stage.sv
// tb_nanosoc_input_hold_stage
//   Directed, self-checking bench for nanosoc_input_hold_stage. Inputs are
//   driven 1 time unit after each rising edge, outputs are sampled on the
//   falling edge, and every expected value is written out by hand.
module tb_nanosoc_input_hold_stage;

  localparam int ADDR_W = 32;

  logic              HCLK;
  logic              HRESETn;
  logic              HSELS;
  logic [ADDR_W-1:0] HADDRS;
  logic [1:0]        HTRANSS;
  logic              HWRITES;
  logic [2:0]        HSIZES;
  logic [2:0]        HBURSTS;
  logic [3:0]        HPROTS;
  logic              HMASTLOCKS;
  logic              HREADYS;
  logic              HREADYOUTS;
  logic              HRESPS;
  logic              sel_m;
  logic [ADDR_W-1:0] addr_m;
  logic [1:0]        trans_m;
  logic              write_m;
  logic [2:0]        size_m;
  logic [2:0]        burst_m;
  logic [3:0]        prot_m;
  logic              mastlock_m;
  logic              trans_req;
  logic              active_dec;
  logic              readyout_dec;
  logic              resp_dec;

  int checkCount;
  int errorCount;

  nanosoc_input_hold_stage #(
    .ADDR_W (ADDR_W)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .HSELS        (HSELS),
    .HADDRS       (HADDRS),
    .HTRANSS      (HTRANSS),
    .HWRITES      (HWRITES),
    .HSIZES       (HSIZES),
    .HBURSTS      (HBURSTS),
    .HPROTS       (HPROTS),
    .HMASTLOCKS   (HMASTLOCKS),
    .HREADYS      (HREADYS),
    .HREADYOUTS   (HREADYOUTS),
    .HRESPS       (HRESPS),
    .sel_m        (sel_m),
    .addr_m       (addr_m),
    .trans_m      (trans_m),
    .write_m      (write_m),
    .size_m       (size_m),
    .burst_m      (burst_m),
    .prot_m       (prot_m),
    .mastlock_m   (mastlock_m),
    .trans_req    (trans_req),
    .active_dec   (active_dec),
    .readyout_dec (readyout_dec),
    .resp_dec     (resp_dec)
  );

  // 10-unit clock period
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // One comparison: count it, report it if it differs
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's worth of master and slave-path inputs. Size, prot and
  // lock use fixed values so the hold of those fields can be checked too.
  task automatic applyStimulus(input logic sel, input logic [1:0] trans,
                               input logic [31:0] addr, input logic wr,
                               input logic [2:0] burst, input logic readys,
                               input logic active, input logic rdy,
                               input logic resp);
    HSELS        = sel;
    HTRANSS      = trans;
    HADDRS       = addr;
    HWRITES      = wr;
    HBURSTS      = burst;
    HSIZES       = 3'b010;
    HPROTS       = 4'b0011;
    HMASTLOCKS   = 1'b0;
    HREADYS      = readys;
    active_dec   = active;
    readyout_dec = rdy;
    resp_dec     = resp;
  endtask

  // Move to the sampling point, then to just after the next rising edge
  task automatic toSample();
    @(negedge HCLK);
  endtask

  task automatic nextCycle();
    @(posedge HCLK);
    #1;
  endtask

  // Main directed sequence
  initial begin
    checkCount = 0;
    errorCount = 0;
    HRESETn = 1'b0;
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset state
    toSample();
    checkOutput("rst_readyout", HREADYOUTS, 1);
    checkOutput("rst_resp", HRESPS, 0);
    checkOutput("rst_req", trans_req, 0);
    checkOutput("rst_sel", sel_m, 0);
    nextCycle();
    HRESETn = 1'b1;

    // Granted NONSEQ read: forwarded in the same cycle, no hold
    applyStimulus(1'b1, 2'b10, 32'h2000_0000, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0);
    toSample();
    checkOutput("g_addr", addr_m, 32'h2000_0000);
    checkOutput("g_req", trans_req, 1);
    checkOutput("g_ready_addr", HREADYOUTS, 1);
    nextCycle();
    // Data phase, slave stalls: ready follows readyout_dec
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    toSample();
    checkOutput("g_dp_stall", HREADYOUTS, 0);
    checkOutput("g_dp_req", trans_req, 0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    toSample();
    checkOutput("g_dp_done", HREADYOUTS, 1);
    nextCycle();
    // No data phase any more: ready is 1 regardless of readyout_dec
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    toSample();
    checkOutput("idle_ready", HREADYOUTS, 1);
    nextCycle();

    // Un-granted NONSEQ write: captured, held 3 cycles, then accepted
    applyStimulus(1'b1, 2'b10, 32'h4000_0010, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    toSample();
    checkOutput("h_cap_addr", addr_m, 32'h4000_0010);
    checkOutput("h_cap_ready", HREADYOUTS, 1);
    checkOutput("h_cap_req", trans_req, 1);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      // Master inputs change to junk; held copy must be what is forwarded.
      // Grant arrives in the third held cycle.
      applyStimulus(1'b0, 2'b01, 32'hDEAD_BEEF, 1'b0, 3'b111, 1'b0,
                    (i == 2), 1'b1, 1'b0);
      toSample();
      checkOutput($sformatf("h_wait_%0d", i), HREADYOUTS, 0);
      checkOutput($sformatf("h_addr_%0d", i), addr_m, 32'h4000_0010);
      checkOutput($sformatf("h_req_%0d", i), trans_req, 1);
      checkOutput($sformatf("h_sel_%0d", i), sel_m, 1);
      checkOutput($sformatf("h_trans_%0d", i), trans_m, 2'b10);
      checkOutput($sformatf("h_write_%0d", i), write_m, 1);
      nextCycle();
    end
    checkOutput("h_size", size_m, 3'b010);
    checkOutput("h_prot", prot_m, 4'b0011);
    // Held transfer accepted: now in data phase, master's inputs pass through
    applyStimulus(1'b0, 2'b00, 32'h0000_0044, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    toSample();
    checkOutput("h_dp_stall", HREADYOUTS, 0);
    checkOutput("h_dp_req", trans_req, 0);
    checkOutput("h_dp_addr", addr_m, 32'h0000_0044);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    toSample();
    checkOutput("h_dp_done", HREADYOUTS, 1);
    nextCycle();

    // Held with grant but previous data phase stalling the slave path
    applyStimulus(1'b1, 2'b10, 32'h3000_0000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    nextCycle();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
      toSample();
      checkOutput($sformatf("st_wait_%0d", i), HREADYOUTS, 0);
      checkOutput($sformatf("st_req_%0d", i), trans_req, 1);
      checkOutput($sformatf("st_addr_%0d", i), addr_m, 32'h3000_0000);
      nextCycle();
    end
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
    toSample();
    checkOutput("st_wait_last", HREADYOUTS, 0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    toSample();
    checkOutput("st_released", trans_req, 0);
    checkOutput("st_dp_ready", HREADYOUTS, 1);
    nextCycle();

    // INCR4 granted throughout: HTRANS sequence passes unchanged
    for (int i = 0; i < 4; i++) begin
      logic [1:0]  beatTrans;
      logic [31:0] beatAddr;
      beatTrans = (i == 0) ? 2'b10 : 2'b11;
      beatAddr  = 32'h0000_0100 + 32'(4 * i);
      applyStimulus(1'b1, beatTrans, beatAddr, 1'b0, 3'b011, 1'b1, 1'b1, 1'b1, 1'b0);
      toSample();
      checkOutput($sformatf("b_trans_%0d", i), trans_m, beatTrans);
      checkOutput($sformatf("b_addr_%0d", i), addr_m, beatAddr);
      checkOutput($sformatf("b_req_%0d", i), trans_req, 1);
      checkOutput($sformatf("b_ready_%0d", i), HREADYOUTS, 1);
      checkOutput($sformatf("b_burst_%0d", i), burst_m, 3'b011);
      nextCycle();
    end

    // BUSY is passed through, never held
    applyStimulus(1'b1, 2'b01, 32'h0000_0110, 1'b0, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0);
    toSample();
    checkOutput("busy_trans", trans_m, 2'b01);
    checkOutput("busy_req", trans_req, 0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    toSample();
    checkOutput("busy_nohold", HREADYOUTS, 1);
    checkOutput("busy_noreq", trans_req, 0);
    nextCycle();

    // Two-cycle ERROR from the slave
    applyStimulus(1'b1, 2'b10, 32'h5000_0000, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    toSample();
    checkOutput("err1_resp", HRESPS, 1);
    checkOutput("err1_ready", HREADYOUTS, 0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1);
    toSample();
    checkOutput("err2_resp", HRESPS, 1);
    checkOutput("err2_ready", HREADYOUTS, 1);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
    toSample();
    checkOutput("err_after_resp", HRESPS, 0);
    checkOutput("err_after_ready", HREADYOUTS, 1);
    nextCycle();

    // Asynchronous reset while holding
    applyStimulus(1'b1, 2'b10, 32'h6000_0000, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 2'b00, 32'h0000_0008, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    toSample();
    checkOutput("ar_pend_req", trans_req, 1);
    checkOutput("ar_pend_ready", HREADYOUTS, 0);
    #2;
    HRESETn = 1'b0;
    #1;
    checkOutput("ar_req", trans_req, 0);
    checkOutput("ar_ready", HREADYOUTS, 1);
    checkOutput("ar_resp", HRESPS, 0);
    checkOutput("ar_sel", sel_m, 0);
    checkOutput("ar_addr", addr_m, 32'h0000_0008);
    nextCycle();
    HRESETn = 1'b1;
    toSample();
    checkOutput("ar_after_req", trans_req, 0);
    checkOutput("ar_after_ready", HREADYOUTS, 1);
    nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
